// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared helpers for the pipelined add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int c_MIN_STAGES = 1;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic bit cfg_ok(
        input int width,
        input int stages
    );
        return (stages >= c_MIN_STAGES) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : adder_chunk
// Description : CW-bit combinational ripple adder slice (a + b + ci).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    logic [CW:0] w_ext;

    assign w_ext   = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
    assign {co, s} = w_ext;

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe
// Description : STAGES-deep pipelined add/subtract with valid/ready flow
//               control, carry/borrow in/out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;

    // The whole pipe moves together; it only freezes when a result is stuck.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_bp = sub ? ~b : b;
    assign w_c0 = cin ^ sub;

    // Stage k consumes the low chunk of the still-unused operand bits, so the
    // operand registers shrink and the partial-sum registers grow per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * CW;

        logic [REM-1:0]        w_a_in;
        logic [REM-1:0]        w_bp_in;
        logic                  w_c_in;
        logic                  w_v_in;
        logic [CW-1:0]         w_chunk_s;
        logic                  w_chunk_co;
        logic [(k+1)*CW-1:0]   w_s_next;

        if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_bp_in  = w_bp;
            assign w_c_in   = w_c0;
            assign w_v_in   = in_valid;
            assign w_s_next = w_chunk_s;
        end else begin : g_body
            assign w_a_in   = g_stage[k-1].g_mid.r_a;
            assign w_bp_in  = g_stage[k-1].g_mid.r_bp;
            assign w_c_in   = g_stage[k-1].g_mid.r_c;
            assign w_v_in   = g_stage[k-1].g_mid.r_v;
            assign w_s_next = {w_chunk_s, g_stage[k-1].g_mid.r_s};
        end

        adder_chunk #(
            .CW (CW)
        ) u_chunk (
            .a  (w_a_in[CW-1:0]),
            .b  (w_bp_in[CW-1:0]),
            .ci (w_c_in),
            .s  (w_chunk_s),
            .co (w_chunk_co)
        );

        if (k < STAGES - 1) begin : g_mid
            logic [REM-CW-1:0]     r_a;
            logic [REM-CW-1:0]     r_bp;
            logic [(k+1)*CW-1:0]   r_s;
            logic                  r_c;
            logic                  r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a  <= '0;
                    r_bp <= '0;
                    r_s  <= '0;
                    r_c  <= 1'b0;
                    r_v  <= 1'b0;
                end else if (w_adv) begin
                    r_a  <= w_a_in[REM-1:CW];
                    r_bp <= w_bp_in[REM-1:CW];
                    r_s  <= w_s_next;
                    r_c  <= w_chunk_co;
                    r_v  <= w_v_in;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] r_sum;
            logic             r_cout;
            logic             r_ovf;
            logic             r_v;

            // The top operand bits reach this stage untouched, so the sign
            // test for overflow is done here on the final sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_v    <= 1'b0;
                end else if (w_adv) begin
                    r_sum  <= w_s_next;
                    r_cout <= w_chunk_co;
                    r_ovf  <= ovf_calc(w_a_in[REM-1], w_bp_in[REM-1], w_s_next[WIDTH-1]);
                    r_v    <= w_v_in;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].g_last.r_v;
    assign sum       = g_stage[STAGES-1].g_last.r_sum;
    assign cout      = g_stage[STAGES-1].g_last.r_cout;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_pipe
// Description : Self-checking bench for adder_pipe (WIDTH=8, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         acc;
        int         st0;
    } exp_t;

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input logic sb_);
        exp_t e;
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int c  = int'(ci);
        int r;
        int sr;
        if (!sb_) begin
            r    = ux + uy + c;
            sr   = sx + sy + c;
            e.co = (r > 255);
        end else begin
            r    = ux - uy - c;
            sr   = sx - sy - c;
            e.co = (r >= 0);
        end
        e.s   = 8'(r);
        e.ov  = (sr > 127) || (sr < -128);
        e.acc = 0;
        e.st0 = 0;
        return e;
    endfunction

    exp_t       sb[$];
    logic [7:0] rx[$];
    int         cyc       = 0;
    int         stall_cnt = 0;
    int         due;

    // Scoreboard: each accepted op must surface STAGES cycles later plus one
    // cycle per stall it sat through, in order, with model-correct fields.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (sb.size() == 0) begin
                chk("idle_out_valid", 32'(out_valid), 32'(0));
            end else begin
                due = sb[0].acc + STAGES + (stall_cnt - sb[0].st0);
                chk("out_valid_timing", 32'(out_valid), 32'(cyc >= due));
                if (out_valid && cyc >= due) begin
                    chk("sb_sum",  32'(sum),  32'(sb[0].s));
                    chk("sb_cout", 32'(cout), 32'(sb[0].co));
                    chk("sb_ovf",  32'(ovf),  32'(sb[0].ov));
                    if (out_ready) begin
                        rx.push_back(sum);
                        void'(sb.pop_front());
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(a, b, cin, sub);
                e.acc = cyc;
                e.st0 = stall_cnt;
                sb.push_back(e);
            end
        end
        cyc++;
    end

    task automatic send(input logic [7:0] xa, input logic [7:0] xb,
                        input logic xc, input logic xs);
        a        = xa;
        b        = xb;
        cin      = xc;
        sub      = xs;
        in_valid = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 29) chk("send_accept", 32'(in_ready), 32'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc, input logic xs,
                          input logic [7:0] es, input logic eco, input logic eov);
        int t = 0;
        send(xa, xb, xc, xs);
        while (!out_valid && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({name, ".valid"},   32'(out_valid), 32'(1));
        chk({name, ".latency"}, 32'(t),         32'(STAGES - 1));
        chk({name, ".sum"},     32'(sum),       32'(es));
        chk({name, ".cout"},    32'(cout),      32'(eco));
        chk({name, ".ovf"},     32'(ovf),       32'(eov));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] corner [4];
        corner[0] = 8'h00;
        corner[1] = 8'h7F;
        corner[2] = 8'h80;
        corner[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'(0));
        chk("rst.sum",       32'(sum),       32'(0));
        chk("rst.cout",      32'(cout),      32'(0));
        chk("rst.ovf",       32'(ovf),       32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_bin",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        run_op("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: stall 3 cycles as soon as the first result shows.
        rx.delete();
        fork
            begin
                for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 1'b0, 1'b0);
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("bp.count", 32'(rx.size()), 32'(4));
        for (int i = 0; i < 4 && i < rx.size(); i++)
            chk($sformatf("bp.res%0d", i), 32'(rx[i]), 32'(2 * (i + 1)));

        // Bubbles: in_valid 1,0,1 shows up as out_valid 1,0,1 two cycles on.
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h02; b = 8'h02;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bubble.v0", 32'(out_valid), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bubble.v1", 32'(out_valid), 32'(0));
        @(negedge clk);
        chk("bubble.v2", 32'(out_valid), 32'(1));
        @(posedge clk);
        #1;

        // Reset with two ops in flight.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h01, 1'b0, 1'b0);
        chk("midrst.pre_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst.async_drop", 32'(out_valid), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst.no_stale", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        run_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        // Random traffic with random sink backpressure.
        for (int i = 0; i < 3000; i++) begin
            a         = pick();
            b         = pick();
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain.empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
